control_unit_gen: RTL and testbench

- Parametrised next-generation control FSM for the single-cycle-datapath processor.
- Sits between the instruction register output and the PC, data memory, register file and ALU. Sequences fetch, decode and execute.
- Extends the ISA with load-immediate and jump-if-zero, a configurable data-memory read latency, sticky illegal-opcode detection and a retired-instruction counter.
- Every output is driven in every state; no inferred latches.

---
 rtl/control_unit_gen_if.sv | 45 ++++
 rtl/control_unit_gen.sv | 208 ++++++++++++++++++++
 tb/tb_control_unit_gen.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_gen_if.sv
// Bus between the control FSM and the datapath: IR contents and status in,
// datapath control, debug state, illegal flag and retired count out.
interface control_unit_gen_if #(
    parameter int unsigned RAW  = 4,
    parameter int unsigned DAW  = 8,
    parameter int unsigned CNTW = 16
);
    localparam int unsigned IW = 4 + RAW + DAW;

    logic [IW-1:0]   data;
    logic            rf_ra_zero;
    logic            PC_clr;
    logic            PC_up;
    logic            PC_ld;
    logic [DAW-1:0]  PC_addr;
    logic            IR_ld;
    logic [DAW-1:0]  D_addr;
    logic            D_wr;
    logic [1:0]      RF_s;
    logic [DAW-1:0]  RF_imm;
    logic [RAW-1:0]  RF_W_addr;
    logic [RAW-1:0]  RF_Ra_addr;
    logic [RAW-1:0]  RF_Rb_addr;
    logic            RF_W_en;
    logic [2:0]      ALU_s0;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] instr_count;
    logic [3:0]      CurrentState;
    logic [3:0]      NextState;

    modport master (
        input  data, rf_ra_zero,
        output PC_clr, PC_up, PC_ld, PC_addr, IR_ld, D_addr, D_wr, RF_s, RF_imm,
               RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s0, halted, illegal,
               instr_count, CurrentState, NextState
    );

    modport slave (
        output data, rf_ra_zero,
        input  PC_clr, PC_up, PC_ld, PC_addr, IR_ld, D_addr, D_wr, RF_s, RF_imm,
               RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s0, halted, illegal,
               instr_count, CurrentState, NextState
    );
endinterface

// File: rtl/control_unit_gen.sv
// Fetch/decode/execute control FSM with load wait states, sticky illegal flag and
// saturating retired-instruction counter. Define CU_SINGLE_STEP_EN to gate FETCH on a step input.
module control_unit_gen #(
    parameter int unsigned RAW     = 4,
    parameter int unsigned DAW     = 8,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNTW    = 16
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic               step,
`endif
    control_unit_gen_if.master bus
);
    localparam int unsigned IW = 4 + RAW + DAW;
    localparam int unsigned WW = 4;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9,
        LOAD_W = 4'd10,
        LDI    = 4'd11,
        JPZ    = 4'd12
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_nxt;
    logic            illegal_q;
    logic            illegal_nxt;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_nxt;
    logic            retire;

    logic [3:0]      opcode;
    logic [RAW-1:0]  fld_a;
    logic [RAW-1:0]  fld_rb;
    logic [RAW-1:0]  fld_rd;
    logic [DAW-1:0]  fld_m;
    logic [DAW-1:0]  fld_k;

    // The A and ra fields occupy the same bits, so one slice serves both.
    assign opcode = bus.data[IW-1 -: 4];
    assign fld_a  = bus.data[IW-5 -: RAW];
    assign fld_rb = bus.data[DAW-1 -: RAW];
    assign fld_rd = bus.data[RAW-1:0];
    assign fld_m  = bus.data[DAW-1:0];
    assign fld_k  = bus.data[RAW +: DAW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            illegal_q <= illegal_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        illegal_nxt    = illegal_q;
        retire         = 1'b0;
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.PC_ld      = 1'b0;
        bus.PC_addr    = '0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 2'd0;
        bus.RF_imm     = '0;
        bus.RF_W_addr  = '0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.RF_W_en    = 1'b0;
        bus.ALU_s0     = 3'd0;
        bus.halted     = 1'b0;

        case (state)
            INIT: begin
                bus.PC_clr = 1'b1;
                state_nxt  = FETCH;
            end
            FETCH: begin
`ifdef CU_SINGLE_STEP_EN
                if (step) begin
                    bus.PC_up = 1'b1;
                    bus.IR_ld = 1'b1;
                    state_nxt = DECODE;
                end
`else
                bus.PC_up = 1'b1;
                bus.IR_ld = 1'b1;
                state_nxt = DECODE;
`endif
            end
            DECODE: begin
                case (opcode)
                    4'd0:    state_nxt = NOOP;
                    4'd1:    state_nxt = STORE;
                    4'd2:    state_nxt = LOAD_A;
                    4'd3:    state_nxt = ADD;
                    4'd4:    state_nxt = SUB;
                    4'd5:    state_nxt = HALT;
                    4'd6:    state_nxt = LDI;
                    4'd7:    state_nxt = JPZ;
                    default: begin
                        state_nxt   = HALT;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            NOOP: begin
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            STORE: begin
                bus.D_addr     = fld_m;
                bus.RF_Ra_addr = fld_a;
                bus.D_wr       = 1'b1;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            LOAD_A: begin
                bus.D_addr = fld_k;
                bus.RF_s   = 2'd1;
                if (MEM_LAT == 0) begin
                    state_nxt = LOAD_B;
                end else begin
                    wait_nxt  = WW'(1);
                    state_nxt = LOAD_W;
                end
            end
            // wait_cnt numbers the LOAD_W cycles 1..MEM_LAT
            LOAD_W: begin
                bus.D_addr = fld_k;
                bus.RF_s   = 2'd1;
                if (wait_cnt >= WW'(MEM_LAT)) begin
                    state_nxt = LOAD_B;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            LOAD_B: begin
                bus.D_addr    = fld_k;
                bus.RF_s      = 2'd1;
                bus.RF_W_addr = fld_rd;
                bus.RF_W_en   = 1'b1;
                retire        = 1'b1;
                state_nxt     = FETCH;
            end
            ADD, SUB: begin
                bus.RF_Ra_addr = fld_a;
                bus.RF_Rb_addr = fld_rb;
                bus.RF_W_addr  = fld_rd;
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state == ADD) ? 3'd1 : 3'd2;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            LDI: begin
                bus.RF_imm    = fld_k;
                bus.RF_s      = 2'd2;
                bus.RF_W_addr = fld_rd;
                bus.RF_W_en   = 1'b1;
                retire        = 1'b1;
                state_nxt     = FETCH;
            end
            JPZ: begin
                bus.RF_Ra_addr = fld_a;
                bus.PC_addr    = fld_m;
                bus.PC_ld      = bus.rf_ra_zero;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: state_nxt = INIT;
        endcase

        cnt_nxt = cnt_q;
        if (retire && (cnt_q != '1)) begin
            cnt_nxt = cnt_q + CNTW'(1);
        end
    end

    assign bus.CurrentState = state;
    assign bus.NextState    = state_nxt;
    assign bus.illegal      = illegal_q;
    assign bus.instr_count  = cnt_q;
endmodule

// File: tb/tb_control_unit_gen.sv
// Bench for control_unit_gen: two instances (MEM_LAT=3/CNTW=16 and MEM_LAT=0/CNTW=2)
// share stimulus; each instruction is checked against a per-instruction cycle trace.
module tb_control_unit_gen;
    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       pc_ld;
        logic [7:0] pc_addr;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic [1:0] rf_s;
        logic [7:0] rf_imm;
        logic [3:0] w_addr;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic       w_en;
        logic [2:0] alu;
        logic       halted;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        zero;
    logic [15:0] data;
`ifdef CU_SINGLE_STEP_EN
    logic        step;
`endif

    int          total;
    int          passed;
    int unsigned cnt_model;
    obs_t        exp_q[$];
    obs_t        got_q[$];
    logic [15:0] got_cnt;
    logic        got_ill;
    obs_t        obs_a;
    obs_t        obs_b;

    control_unit_gen_if #(.RAW(4), .DAW(8), .CNTW(16)) bus_a ();
    control_unit_gen_if #(.RAW(4), .DAW(8), .CNTW(2))  bus_b ();

    assign bus_a.data       = data;
    assign bus_a.rf_ra_zero = zero;
    assign bus_b.data       = data;
    assign bus_b.rf_ra_zero = zero;

    control_unit_gen #(.RAW(4), .DAW(8), .MEM_LAT(3), .CNTW(16)) dut_a (
        .clk   (clk),
        .reset (reset),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus_a)
    );

    control_unit_gen #(.RAW(4), .DAW(8), .MEM_LAT(0), .CNTW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus_b)
    );

    assign obs_a = '{st: bus_a.CurrentState, pc_clr: bus_a.PC_clr, pc_up: bus_a.PC_up,
                     pc_ld: bus_a.PC_ld, pc_addr: bus_a.PC_addr, ir_ld: bus_a.IR_ld,
                     d_addr: bus_a.D_addr, d_wr: bus_a.D_wr, rf_s: bus_a.RF_s,
                     rf_imm: bus_a.RF_imm, w_addr: bus_a.RF_W_addr, ra_addr: bus_a.RF_Ra_addr,
                     rb_addr: bus_a.RF_Rb_addr, w_en: bus_a.RF_W_en, alu: bus_a.ALU_s0,
                     halted: bus_a.halted};
    assign obs_b = '{st: bus_b.CurrentState, pc_clr: bus_b.PC_clr, pc_up: bus_b.PC_up,
                     pc_ld: bus_b.PC_ld, pc_addr: bus_b.PC_addr, ir_ld: bus_b.IR_ld,
                     d_addr: bus_b.D_addr, d_wr: bus_b.D_wr, rf_s: bus_b.RF_s,
                     rf_imm: bus_b.RF_imm, w_addr: bus_b.RF_W_addr, ra_addr: bus_b.RF_Ra_addr,
                     rb_addr: bus_b.RF_Rb_addr, w_en: bus_b.RF_W_en, alu: bus_b.ALU_s0,
                     halted: bus_b.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_of(input bit sel);
        return sel ? obs_b : obs_a;
    endfunction

    function automatic logic [15:0] cnt_of(input bit sel);
        return sel ? 16'(bus_b.instr_count) : bus_a.instr_count;
    endfunction

    function automatic logic ill_of(input bit sel);
        return sel ? bus_b.illegal : bus_a.illegal;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // Retired count after one instruction: halting opcodes never retire.
    function automatic int unsigned bump(input int unsigned c, input logic [15:0] d,
                                         input int unsigned max);
        if (d[15] || d[15:12] == 4'd5) return c;
        return (c < max) ? c + 1 : c;
    endfunction

    // Expected per-cycle outputs of one instruction, from FETCH to its last execute cycle.
    task automatic build_trace(input logic [15:0] d, input logic z, input int lat);
        obs_t o;
        exp_q.delete();
        o = blank(4'd1);
        o.pc_up = 1'b1;
        o.ir_ld = 1'b1;
        exp_q.push_back(o);
        exp_q.push_back(blank(4'd2));
        case (d[15:12])
            4'd0: exp_q.push_back(blank(4'd3));
            4'd1: begin
                o = blank(4'd6);
                o.d_addr = d[7:0];
                o.ra_addr = d[11:8];
                o.d_wr = 1'b1;
                exp_q.push_back(o);
            end
            4'd2: begin
                o = blank(4'd4);
                o.d_addr = d[11:4];
                o.rf_s = 2'd1;
                exp_q.push_back(o);
                o.st = 4'd10;
                for (int i = 0; i < lat; i++) exp_q.push_back(o);
                o.st = 4'd5;
                o.w_addr = d[3:0];
                o.w_en = 1'b1;
                exp_q.push_back(o);
            end
            4'd3, 4'd4: begin
                o = blank((d[15:12] == 4'd3) ? 4'd7 : 4'd8);
                o.ra_addr = d[11:8];
                o.rb_addr = d[7:4];
                o.w_addr = d[3:0];
                o.w_en = 1'b1;
                o.alu = (d[15:12] == 4'd3) ? 3'd1 : 3'd2;
                exp_q.push_back(o);
            end
            4'd6: begin
                o = blank(4'd11);
                o.rf_imm = d[11:4];
                o.rf_s = 2'd2;
                o.w_addr = d[3:0];
                o.w_en = 1'b1;
                exp_q.push_back(o);
            end
            4'd7: begin
                o = blank(4'd12);
                o.ra_addr = d[11:8];
                o.pc_addr = d[7:0];
                o.pc_ld = z;
                exp_q.push_back(o);
            end
            default: begin
                o = blank(4'd9);
                o.halted = 1'b1;
                for (int i = 0; i < 12; i++) exp_q.push_back(o);
            end
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        data = '0;
        zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cnt_model = 0;
    endtask

    // Drives one instruction from FETCH and records as many cycles as the trace holds.
    task automatic run_instr(input bit sel, input logic [15:0] d, input logic z);
        got_q.delete();
        @(posedge clk); #1;
        data = d;
        zero = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) got_cnt = cnt_of(sel);
            got_q.push_back(obs_of(sel));
            got_ill = ill_of(sel);
            if (i < exp_q.size() - 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        obs_t e;
        do_reset();
        @(negedge clk);
        e = blank(4'd0);
        e.pc_clr = 1'b1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (obs_of(s[0]) !== e)
                $display("FAIL reset_outputs dut%0d: got %h want %h", s, obs_of(s[0]), e);
            else passed++;
            total++;
            if (cnt_of(s[0]) !== 16'd0 || ill_of(s[0]) !== 1'b0)
                $display("FAIL reset_status dut%0d: got count %0d illegal %b want 0 0",
                         s, cnt_of(s[0]), ill_of(s[0]));
            else passed++;
        end
    endtask

    task automatic test_nop();
        for (int n = 0; n < 3; n++) begin
            build_trace(16'h0000, 1'b0, 3);
            run_instr(1'b0, 16'h0000, 1'b0);
            total++;
            if (got_cnt !== 16'(cnt_model))
                $display("FAIL nop_count: got %0d want %0d", got_cnt, cnt_model);
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL nop cycle %0d: got %h want %h", i, got_q[i], exp_q[i]);
                else passed++;
            end
            cnt_model = bump(cnt_model, 16'h0000, 65535);
        end
    endtask

    task automatic test_store();
        logic [15:0] ds[2];
        ds[0] = 16'h1F29;
        ds[1] = {4'h1, 12'($urandom)};
        foreach (ds[k]) begin
            build_trace(ds[k], 1'b0, 3);
            run_instr(1'b0, ds[k], 1'b0);
            total++;
            if (got_cnt !== 16'(cnt_model))
                $display("FAIL store_count: got %0d want %0d", got_cnt, cnt_model);
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL store %h cycle %0d: got %h want %h", ds[k], i, got_q[i], exp_q[i]);
                else passed++;
            end
            cnt_model = bump(cnt_model, ds[k], 65535);
        end
    endtask

    task automatic test_load_latency();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            build_trace(16'h20A7, 1'b0, (s == 0) ? 3 : 0);
            run_instr(s[0], 16'h20A7, 1'b0);
            total++;
            if (exp_q.size() !== got_q.size())
                $display("FAIL load_len dut%0d: got %0d want %0d", s, got_q.size(), exp_q.size());
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL load dut%0d cycle %0d: got %h want %h", s, i, got_q[i], exp_q[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_ldi_jpz();
        logic [15:0] ds[3];
        logic        zs[3];
        do_reset();
        ds[0] = 16'h6FF2; zs[0] = 1'b0;
        ds[1] = 16'h7140; zs[1] = 1'b1;
        ds[2] = 16'h7140; zs[2] = 1'b0;
        foreach (ds[k]) begin
            build_trace(ds[k], zs[k], 3);
            run_instr(1'b0, ds[k], zs[k]);
            total++;
            if (got_cnt !== 16'(cnt_model))
                $display("FAIL ldi_jpz_count: got %0d want %0d", got_cnt, cnt_model);
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL ldi_jpz %h z%b cycle %0d: got %h want %h",
                             ds[k], zs[k], i, got_q[i], exp_q[i]);
                else passed++;
            end
            cnt_model = bump(cnt_model, ds[k], 65535);
        end
    endtask

    task automatic test_random();
        int          ops[7];
        logic [15:0] d;
        logic        z;
        ops = '{0, 1, 2, 3, 4, 6, 7};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            d = {4'(ops[$urandom_range(6)]), 12'($urandom)};
            z = 1'($urandom_range(1));
            build_trace(d, z, 3);
            run_instr(1'b0, d, z);
            total++;
            if (got_cnt !== 16'(cnt_model))
                $display("FAIL random_count #%0d: got %0d want %0d", n, got_cnt, cnt_model);
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL random #%0d %h cycle %0d: got %h want %h", n, d, i, got_q[i], exp_q[i]);
                else passed++;
            end
            cnt_model = bump(cnt_model, d, 65535);
        end
    endtask

    task automatic test_reset_mid_load();
        obs_t o;
        obs_t e;
        @(posedge clk); #1;
        data = 16'h2C35;
        zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = obs_of(1'b0);
        total++;
        if (o.st !== 4'd10 || o.w_en !== 1'b0)
            $display("FAIL midload_wait: got state %0d wen %b want 10 0", o.st, o.w_en);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cnt_model = 0;
        @(negedge clk);
        e = blank(4'd0);
        e.pc_clr = 1'b1;
        total++;
        if (obs_of(1'b0) !== e)
            $display("FAIL midload_init: got %h want %h", obs_of(1'b0), e);
        else passed++;
        total++;
        if (cnt_of(1'b0) !== 16'd0 || ill_of(1'b0) !== 1'b0)
            $display("FAIL midload_status: got count %0d illegal %b want 0 0", cnt_of(1'b0), ill_of(1'b0));
        else passed++;
        build_trace(16'h2C35, 1'b0, 3);
        run_instr(1'b0, 16'h2C35, 1'b0);
        foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL midload_reload cycle %0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            d = (n < 5) ? {4'h3, 12'($urandom)} : 16'h0000;
            build_trace(d, 1'b0, 0);
            run_instr(1'b1, d, 1'b0);
            total++;
            if (got_cnt !== 16'(cnt_model))
                $display("FAIL sat_count #%0d: got %0d want %0d", n, got_cnt, cnt_model);
            else passed++;
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL sat #%0d cycle %0d: got %h want %h", n, i, got_q[i], exp_q[i]);
                else passed++;
            end
            cnt_model = bump(cnt_model, d, 3);
        end
    endtask

    task automatic test_halt_illegal();
        logic [15:0] ds[3];
        ds[0] = 16'hC000;
        ds[1] = 16'h5000;
        ds[2] = {4'(8 + $urandom_range(7)), 12'($urandom)};
        foreach (ds[k]) begin
            do_reset();
            build_trace(ds[k], 1'b0, 3);
            run_instr(1'b0, ds[k], 1'b0);
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL halt %h cycle %0d: got %h want %h", ds[k], i, got_q[i], exp_q[i]);
                else passed++;
            end
            total++;
            if (got_ill !== ds[k][15])
                $display("FAIL halt_illegal %h: got %b want %b", ds[k], got_ill, ds[k][15]);
            else passed++;
            total++;
            if (cnt_of(1'b0) !== 16'd0)
                $display("FAIL halt_count %h: got %0d want 0", ds[k], cnt_of(1'b0));
            else passed++;
        end
    endtask

`ifdef CU_SINGLE_STEP_EN
    task automatic test_single_step();
        obs_t e;
        do_reset();
        step = 1'b0;
        @(posedge clk); #1;
        data = 16'h0000;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            total++;
            if (obs_of(1'b0) !== blank(4'd1))
                $display("FAIL step_hold #%0d: got %h want %h", n, obs_of(1'b0), blank(4'd1));
            else passed++;
            @(posedge clk); #1;
        end
        step = 1'b1;
        @(negedge clk);
        e = blank(4'd1);
        e.pc_up = 1'b1;
        e.ir_ld = 1'b1;
        total++;
        if (obs_of(1'b0) !== e)
            $display("FAIL step_go: got %h want %h", obs_of(1'b0), e);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (obs_of(1'b0) !== blank(4'd2))
            $display("FAIL step_decode: got %h want %h", obs_of(1'b0), blank(4'd2));
        else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        passed = 0;
        cnt_model = 0;
        reset = 1'b1;
        data = '0;
        zero = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        test_reset();
        test_nop();
        test_store();
        test_load_latency();
        test_ldi_jpz();
        test_random();
        test_reset_mid_load();
        test_saturation();
        test_halt_illegal();
`ifdef CU_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
